// File: rtl/asteroid_hit_ctrl_if.sv
// Signal bundle between the asteroid hit controller and the rest of the game.
// The slave modport is the controller's view; the master modport is the
// environment: the sprite units, the VGA timing and the start screen.
interface asteroid_hit_ctrl_if #(
  parameter int unsigned SCORE_W = 16
) ();

  // Frame timing and game mode
  logic               vsync;
  logic               start_done;

  // Per-pixel opacity from the sprite units
  logic               ast_pixel;
  logic               torp_pixel;
  logic               ship_pixel;

  // Value of the asteroid at its current size
  logic [6:0]         ast_points;

  // Controller outputs
  logic               new_asteroid;
  logic               asteroid_hit;
  logic               torp_kill;
  logic               ship_hit;
  logic               ast_visible;
  logic               ship_visible;
  logic               game_over;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;

  modport master (
    output vsync,
    output start_done,
    output ast_pixel,
    output torp_pixel,
    output ship_pixel,
    output ast_points,
    input  new_asteroid,
    input  asteroid_hit,
    input  torp_kill,
    input  ship_hit,
    input  ast_visible,
    input  ship_visible,
    input  game_over,
    input  score,
    input  lives
  );

  modport slave (
    input  vsync,
    input  start_done,
    input  ast_pixel,
    input  torp_pixel,
    input  ship_pixel,
    input  ast_points,
    output new_asteroid,
    output asteroid_hit,
    output torp_kill,
    output ship_hit,
    output ast_visible,
    output ship_visible,
    output game_over,
    output score,
    output lives
  );

endinterface

// File: rtl/asteroid_hit_ctrl.sv
// Asteroid game-rule controller.
// Latches pixel collisions during a frame, evaluates them on vsync and drives
// the asteroid sprite unit (new_asteroid / asteroid_hit / torp_kill). Keeps
// score, ship lives and the game-over state.
// Optional feature: define ASTEROID_EXTRA_LIFE_EN to award one life each time
// the score crosses a multiple of EXTRA_LIFE_PTS. Undefined by default.
module asteroid_hit_ctrl #(
  parameter int unsigned SCORE_W        = 16,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned HIT_COOLDOWN   = 8,
  parameter int unsigned RESPAWN_FRAMES = 60,
  parameter int unsigned DEAD_FRAMES    = 120,
  parameter int unsigned EXTRA_LIFE_PTS = 1000
) (
  input logic                clk,
  input logic                resetN,
  asteroid_hit_ctrl_if.slave bus
);

  // Frame counter is sized for the longest wait of any timed state.
  localparam int unsigned MaxFrames =
      (HIT_COOLDOWN >= RESPAWN_FRAMES && HIT_COOLDOWN >= DEAD_FRAMES) ? HIT_COOLDOWN :
      (RESPAWN_FRAMES >= DEAD_FRAMES) ? RESPAWN_FRAMES : DEAD_FRAMES;
  localparam int unsigned CntW = $clog2(MaxFrames + 1);

  // A timed state exits on the vsync seen while the counter holds N-1.
  localparam logic [CntW-1:0] CoolLast    = CntW'(HIT_COOLDOWN - 1);
  localparam logic [CntW-1:0] RespawnLast = CntW'(RESPAWN_FRAMES - 1);
  localparam logic [CntW-1:0] DeadLast    = CntW'(DEAD_FRAMES - 1);
  localparam logic [CntW-1:0] FrameOne    = CntW'(1);

  localparam logic [2:0] LivesInit = 3'(LIVES);
  localparam logic [2:0] LivesMax  = 3'd7;
  localparam logic [1:0] StageSmall = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StPlay,
    StCooldown,
    StRespawn,
    StShipDead,
    StGameOver
  } state_e;

  state_e             state_q;
  logic [CntW-1:0]    frame_cnt_q;
  logic [1:0]         stage_q;
  logic               torp_f_q;
  logic               ship_f_q;
  logic               respawn_pend_q;
  logic               new_ast_q;
  logic               ast_hit_q;
  logic               torp_kill_q;
  logic               ship_hit_q;
  logic               ast_vis_q;
  logic               ship_vis_q;
  logic               game_over_q;
  logic [SCORE_W-1:0] score_q;
  logic [2:0]         lives_q;

  logic               torp_col;
  logic               ship_col;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_add;
  logic               add_en;
  logic               life_cross;

  assign torp_col = bus.ast_pixel & bus.torp_pixel;
  assign ship_col = bus.ast_pixel & bus.ship_pixel;

  // ast_points is taken in the cycle the asteroid_hit pulse is high, i.e.
  // before the sprite unit has shrunk the asteroid.
  assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(bus.ast_points);
  assign score_add = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  assign add_en    = ast_hit_q & (state_q != StGameOver);

`ifdef ASTEROID_EXTRA_LIFE_EN
  localparam logic [SCORE_W:0] LifeStep = (SCORE_W + 1)'(EXTRA_LIFE_PTS);

  // Next score that earns a life; always above the current score, so a
  // single compare detects a crossing and one add awards at most one life.
  logic [SCORE_W:0] life_thr_q;

  assign life_cross = ({1'b0, score_add} >= life_thr_q);

  // Advance the extra-life threshold by one step per crossing; restart with the game.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      life_thr_q <= LifeStep;
    end else if (bus.start_done) begin
      if (state_q == StIdle) begin
        life_thr_q <= LifeStep;
      end else if (add_en && life_cross) begin
        life_thr_q <= life_thr_q + LifeStep;
      end
    end
  end
`else
  logic unused_extra_life_pts;

  assign life_cross            = 1'b0;
  assign unused_extra_life_pts = ^EXTRA_LIFE_PTS;
`endif

  // Game FSM with all pulses, levels, score and lives registered.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= StIdle;
      frame_cnt_q    <= '0;
      stage_q        <= 2'd0;
      torp_f_q       <= 1'b0;
      ship_f_q       <= 1'b0;
      respawn_pend_q <= 1'b0;
      new_ast_q      <= 1'b0;
      ast_hit_q      <= 1'b0;
      torp_kill_q    <= 1'b0;
      ship_hit_q     <= 1'b0;
      ast_vis_q      <= 1'b1;
      ship_vis_q     <= 1'b1;
      game_over_q    <= 1'b0;
      score_q        <= '0;
      lives_q        <= LivesInit;
    end else begin
      // Pulses are single-cycle unless re-asserted below.
      new_ast_q   <= 1'b0;
      ast_hit_q   <= 1'b0;
      torp_kill_q <= 1'b0;
      ship_hit_q  <= 1'b0;

      if (!bus.start_done) begin
        // Back to the title screen; score stays on display until next start.
        state_q        <= StIdle;
        frame_cnt_q    <= '0;
        torp_f_q       <= 1'b0;
        ship_f_q       <= 1'b0;
        respawn_pend_q <= 1'b0;
        ast_vis_q      <= 1'b1;
        ship_vis_q     <= 1'b1;
        game_over_q    <= 1'b0;
      end else begin
        // Score add lands one cycle after the hit pulse, whatever the state.
        if (add_en) begin
          score_q <= score_add;
          if (life_cross && (lives_q != LivesMax)) begin
            lives_q <= lives_q + 3'd1;
          end
        end

        unique case (state_q)
          StIdle: begin
            state_q     <= StPlay;
            frame_cnt_q <= '0;
            score_q     <= '0;
            lives_q     <= LivesInit;
            stage_q     <= 2'd0;
            new_ast_q   <= 1'b1;
            torp_f_q    <= 1'b0;
            ship_f_q    <= 1'b0;
          end

          StPlay: begin
            if (bus.vsync) begin
              if (torp_f_q) begin
                ast_hit_q   <= 1'b1;
                torp_kill_q <= 1'b1;
                if (stage_q == StageSmall) begin
                  stage_q        <= 2'd0;
                  respawn_pend_q <= 1'b1;
                  ast_vis_q      <= 1'b0;
                end else begin
                  stage_q <= stage_q + 2'd1;
                end
              end
              if (ship_f_q) begin
                // Ship death takes priority; a pending respawn is served on exit.
                ship_hit_q  <= 1'b1;
                ship_vis_q  <= 1'b0;
                state_q     <= StShipDead;
                frame_cnt_q <= '0;
                torp_f_q    <= 1'b0;
                ship_f_q    <= 1'b0;
                if (lives_q != 3'd0) begin
                  lives_q <= lives_q - 3'd1;
                end
              end else if (torp_f_q) begin
                state_q     <= (stage_q == StageSmall) ? StRespawn : StCooldown;
                frame_cnt_q <= '0;
                torp_f_q    <= 1'b0;
                ship_f_q    <= 1'b0;
              end else begin
                // Collision in the vsync cycle itself belongs to the next frame.
                torp_f_q <= torp_col;
                ship_f_q <= ship_col;
              end
            end else begin
              torp_f_q <= torp_f_q | torp_col;
              ship_f_q <= ship_f_q | ship_col;
            end
          end

          StCooldown: begin
            if (bus.vsync) begin
              if (frame_cnt_q == CoolLast) begin
                state_q     <= StPlay;
                frame_cnt_q <= '0;
              end else begin
                frame_cnt_q <= frame_cnt_q + FrameOne;
              end
            end
          end

          StRespawn: begin
            if (bus.vsync) begin
              if (frame_cnt_q == RespawnLast) begin
                state_q        <= StPlay;
                frame_cnt_q    <= '0;
                new_ast_q      <= 1'b1;
                ast_vis_q      <= 1'b1;
                respawn_pend_q <= 1'b0;
              end else begin
                frame_cnt_q <= frame_cnt_q + FrameOne;
              end
            end
          end

          StShipDead: begin
            if (bus.vsync) begin
              if (frame_cnt_q == DeadLast) begin
                frame_cnt_q <= '0;
                if (lives_q == 3'd0) begin
                  state_q     <= StGameOver;
                  game_over_q <= 1'b1;
                end else begin
                  state_q    <= StPlay;
                  ship_vis_q <= 1'b1;
                  if (respawn_pend_q) begin
                    new_ast_q      <= 1'b1;
                    ast_vis_q      <= 1'b1;
                    respawn_pend_q <= 1'b0;
                  end
                end
              end else begin
                frame_cnt_q <= frame_cnt_q + FrameOne;
              end
            end
          end

          StGameOver: begin
            game_over_q <= 1'b1;
          end

          default: begin
            state_q     <= StIdle;
            frame_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.new_asteroid = new_ast_q;
  assign bus.asteroid_hit = ast_hit_q;
  assign bus.torp_kill    = torp_kill_q;
  assign bus.ship_hit     = ship_hit_q;
  assign bus.ast_visible  = ast_vis_q;
  assign bus.ship_visible = ship_vis_q;
  assign bus.game_over    = game_over_q;
  assign bus.score        = score_q;
  assign bus.lives        = lives_q;

endmodule

// File: tb/tb_asteroid_hit_ctrl.sv
// Bench for asteroid_hit_ctrl: frames of pixel stimulus, pulse scoreboard keyed
// on the expected cycle, and direct checks of score, lives and visibility.
module tb_asteroid_hit_ctrl;

`ifdef ASTEROID_EXTRA_LIFE_EN
  localparam int unsigned ExtraLife = 1;
`else
  localparam int unsigned ExtraLife = 0;
`endif

  // Pulse vector order: {new_asteroid, asteroid_hit, torp_kill, ship_hit}
  localparam logic [3:0] PNone = 4'b0000;
  localparam logic [3:0] PNew  = 4'b1000;
  localparam logic [3:0] PHit  = 4'b0110;
  localparam logic [3:0] PShip = 4'b0001;
  localparam logic [3:0] PBoth = 4'b0111;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  vec;
  } sb_entry_t;

  logic        clk;
  logic        resetN;
  int unsigned cyc;
  int          n_checks;
  int          n_errors;
  sb_entry_t   sb[$];
  int          exp_score;

  asteroid_hit_ctrl_if #(.SCORE_W(16)) bus ();

  asteroid_hit_ctrl dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] vec);
    sb_entry_t e;
    e.cyc = cyc + 1;
    e.vec = vec;
    sb.push_back(e);
  endtask

  // One short frame: optional collision in the first cycle (or in the vsync
  // cycle when at_vs is set), then vsync. Returns in the cycle after vsync.
  task automatic frame(input logic a, input logic t, input logic s, input logic at_vs,
                       input logic [3:0] exp);
    bus.ast_pixel  = a & ~at_vs;
    bus.torp_pixel = t & ~at_vs;
    bus.ship_pixel = s & ~at_vs;
    tick();
    bus.ast_pixel  = 1'b0;
    bus.torp_pixel = 1'b0;
    bus.ship_pixel = 1'b0;
    tick();
    tick();
    bus.vsync      = 1'b1;
    bus.ast_pixel  = a & at_vs;
    bus.torp_pixel = t & at_vs;
    bus.ship_pixel = s & at_vs;
    if (exp != PNone) push_exp(exp);
    tick();
    bus.vsync      = 1'b0;
    bus.ast_pixel  = 1'b0;
    bus.torp_pixel = 1'b0;
    bus.ship_pixel = 1'b0;
  endtask

  // Scoreboard: every pulse cycle must match the head entry's cycle and vector.
  always @(negedge clk) begin : monitor
    logic [3:0] pv;
    sb_entry_t  e;
    pv = {bus.new_asteroid, bus.asteroid_hit, bus.torp_kill, bus.ship_hit};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      check_val("pulse_missing", 32'(PNone), 32'(e.vec));
    end
    if (pv != PNone) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check_val("pulse_vec", 32'(pv), 32'(e.vec));
      end else begin
        check_val("pulse_unexpected", 32'(pv), 32'(PNone));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pts_tab [9] = '{127, 127, 127, 127, 127, 127, 127, 91, 20};

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    resetN   = 1'b0;
    bus.vsync      = 1'b0;
    bus.start_done = 1'b0;
    bus.ast_pixel  = 1'b0;
    bus.torp_pixel = 1'b0;
    bus.ship_pixel = 1'b0;
    bus.ast_points = 7'd0;

    // Reset values
    tick();
    tick();
    check_val("rst_score", 32'(bus.score), 0);
    check_val("rst_lives", 32'(bus.lives), 3);
    check_val("rst_game_over", 32'(bus.game_over), 0);
    check_val("rst_ast_vis", 32'(bus.ast_visible), 1);
    check_val("rst_ship_vis", 32'(bus.ship_visible), 1);
    resetN = 1'b1;
    tick();

    // Title screen: collisions and vsync produce nothing
    frame(1'b1, 1'b1, 1'b1, 1'b0, PNone);

    // 1: start -> new_asteroid one cycle later
    bus.start_done = 1'b1;
    push_exp(PNew);
    tick();
    check_val("start_score", 32'(bus.score), 0);
    check_val("start_lives", 32'(bus.lives), 3);

    // 2: first hit, score visible two cycles after vsync, cooldown ignores collisions
    bus.ast_points = 7'd20;
    frame(1'b1, 1'b1, 1'b0, 1'b0, PHit);
    check_val("hit1_score_n1", 32'(bus.score), 0);
    tick();
    check_val("hit1_score_n2", 32'(bus.score), 20);
    for (int i = 0; i < 8; i++) frame(1'b1, 1'b1, 1'b1, 1'b0, PNone);
    check_val("cool_lives", 32'(bus.lives), 3);

    // 3: medium and small hits, respawn after 60 frames
    bus.ast_points = 7'd50;
    frame(1'b1, 1'b1, 1'b0, 1'b0, PHit);
    tick();
    check_val("hit2_score", 32'(bus.score), 70);
    for (int i = 0; i < 8; i++) frame(1'b0, 1'b0, 1'b0, 1'b0, PNone);
    bus.ast_points = 7'd100;
    frame(1'b1, 1'b1, 1'b0, 1'b0, PHit);
    check_val("respawn_ast_vis0", 32'(bus.ast_visible), 0);
    tick();
    check_val("hit3_score", 32'(bus.score), 170);
    for (int i = 1; i <= 60; i++) begin
      frame(1'b1, 1'b1, 1'b1, 1'b0, (i == 60) ? PNew : PNone);
      if (i == 59) check_val("respawn_ast_vis59", 32'(bus.ast_visible), 0);
    end
    check_val("respawn_ast_vis1", 32'(bus.ast_visible), 1);

    // 4: ship and torpedo collide in one frame
    bus.ast_points = 7'd20;
    frame(1'b1, 1'b1, 1'b1, 1'b0, PBoth);
    check_val("both_lives", 32'(bus.lives), 2);
    check_val("both_ship_vis", 32'(bus.ship_visible), 0);
    check_val("both_ast_vis", 32'(bus.ast_visible), 1);
    tick();
    check_val("both_score", 32'(bus.score), 190);
    for (int i = 1; i <= 120; i++) begin
      frame(1'b1, 1'b1, 1'b1, 1'b0, PNone);
      if (i == 119) check_val("dead_ship_vis119", 32'(bus.ship_visible), 0);
    end
    check_val("dead_ship_vis1", 32'(bus.ship_visible), 1);

    // 5: stage-2 hit coinciding with ship death respawns on exit, then game over
    frame(1'b1, 1'b1, 1'b0, 1'b0, PHit);
    tick();
    check_val("pre_score", 32'(bus.score), 210);
    for (int i = 0; i < 8; i++) frame(1'b0, 1'b0, 1'b0, 1'b0, PNone);
    frame(1'b1, 1'b1, 1'b1, 1'b0, PBoth);
    check_val("death2_lives", 32'(bus.lives), 1);
    tick();
    check_val("death2_score", 32'(bus.score), 230);
    for (int i = 1; i <= 120; i++) frame(1'b0, 1'b0, 1'b0, 1'b0, (i == 120) ? PNew : PNone);
    check_val("death2_ast_vis", 32'(bus.ast_visible), 1);
    frame(1'b1, 1'b0, 1'b1, 1'b0, PShip);
    check_val("death3_lives", 32'(bus.lives), 0);
    for (int i = 1; i <= 120; i++) frame(1'b0, 1'b0, 1'b0, 1'b0, PNone);
    check_val("go_game_over", 32'(bus.game_over), 1);
    check_val("go_ship_vis", 32'(bus.ship_visible), 0);
    frame(1'b1, 1'b1, 1'b1, 1'b0, PNone);
    check_val("go_score_frozen", 32'(bus.score), 230);
    check_val("go_lives_frozen", 32'(bus.lives), 0);
    bus.start_done = 1'b0;
    tick();
    check_val("idle_game_over", 32'(bus.game_over), 0);
    check_val("idle_ship_vis", 32'(bus.ship_visible), 1);
    check_val("idle_score_kept", 32'(bus.score), 230);
    tick();
    bus.start_done = 1'b1;
    push_exp(PNew);
    tick();
    check_val("restart_score", 32'(bus.score), 0);
    check_val("restart_lives", 32'(bus.lives), 3);
    check_val("restart_game_over", 32'(bus.game_over), 0);

    // 6: climb to 980 then +20; vsync-cycle collision deferred on first hit
    exp_score = 0;
    for (int k = 0; k < 9; k++) begin
      bus.ast_points = 7'(pts_tab[k]);
      if (k == 0) begin
        frame(1'b1, 1'b1, 1'b0, 1'b1, PNone);
        frame(1'b0, 1'b0, 1'b0, 1'b0, PHit);
      end else begin
        frame(1'b1, 1'b1, 1'b0, 1'b0, PHit);
      end
      check_val("climb_score_hold", 32'(bus.score), 32'(exp_score));
      tick();
      exp_score += pts_tab[k];
      check_val("climb_score", 32'(bus.score), 32'(exp_score));
      check_val("climb_lives", 32'(bus.lives), (k == 8) ? 32'(3 + ExtraLife) : 32'd3);
      if (k % 3 == 2) begin
        for (int i = 1; i <= 60; i++) frame(1'b0, 1'b0, 1'b0, 1'b0, (i == 60) ? PNew : PNone);
      end else begin
        for (int i = 0; i < 8; i++) frame(1'b0, 1'b0, 1'b0, 1'b0, PNone);
      end
    end

    tick();
    tick();
    check_val("sb_drain", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
